// File: rtl/updi_pkg.sv
// Shared UPDI definitions: frame layout, line idle level, transmitter states
// and the frame-to-wire bit reordering used by the serializer.
package updi_pkg;

    localparam int UPDI_FRAME_W = 12;
    localparam int START_BIT    = 11;
    localparam int DATA_MSB     = 10;
    localparam int DATA_LSB     = 3;
    localparam int PARITY_BIT   = 2;
    localparam int STOP_MSB     = 1;
    localparam int STOP_LSB     = 0;

    localparam logic UPDI_IDLE = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GUARD = 2'd2
    } updi_tx_state_e;

    // Bit k of the result is the k-th bit to appear on the wire.
    function automatic logic [UPDI_FRAME_W-1:0] updi_wire_order(
        input logic [UPDI_FRAME_W-1:0] frame
    );
        logic [UPDI_FRAME_W-1:0] w;
        w    = '0;
        w[0] = frame[START_BIT];
        for (int i = 0; i <= DATA_MSB - DATA_LSB; i++) begin
            w[1 + i] = frame[DATA_LSB + i];
        end
        w[9]  = frame[PARITY_BIT];
        w[10] = frame[STOP_MSB];
        w[11] = frame[STOP_LSB];
        return w;
    endfunction

endpackage

// File: rtl/updi_baud_gen.sv
// Bit-period timer: pulses bit_tick on the last clock of every CLK_DIV-cycle
// bit period while enabled; clear re-phases the period to the current cycle.
module updi_baud_gen #(
    parameter int CLK_DIV = 16
) (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_bit_tick
);

    localparam int               CNT_W   = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] r_baud_cnt;
    logic             w_at_max;

    assign w_at_max   = (r_baud_cnt == CNT_MAX);
    assign o_bit_tick = i_enable & w_at_max;

    // Period counter, wraps at CLK_DIV-1 and holds while disabled
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_baud_cnt <= '0;
        end else if (i_clear) begin
            r_baud_cnt <= '0;
        end else if (i_enable) begin
            r_baud_cnt <= w_at_max ? '0 : r_baud_cnt + CNT_W'(1);
        end else begin
            r_baud_cnt <= r_baud_cnt;
        end
    end

endmodule

// File: rtl/updi_tx_serializer.sv
// UPDI bit transmitter: one-frame skid buffer, LSB-first shifter, guard
// interval and line release. Line outputs are registered from the FSM state.
module updi_tx_serializer
    import updi_pkg::*;
#(
    parameter int CLK_DIV    = 16,
    parameter int GUARD_BITS = 2
) (
    input  logic                    i_clk,
    input  logic                    i_rstn,
    input  logic [UPDI_FRAME_W-1:0] i_data,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic                    i_trans_en,
    output logic                    o_tx,
    output logic                    o_tx_oe,
    output logic                    o_busy,
    output logic                    o_done
);

    localparam logic [7:0] GUARD_LAST = 8'(GUARD_BITS - 1);

    updi_tx_state_e r_state;
    updi_tx_state_e w_state_nxt;

    logic [UPDI_FRAME_W-1:0] r_hold;
    logic                    r_hold_vld;
    logic [UPDI_FRAME_W-1:0] r_shift;
    logic [3:0]              r_bit_cnt;
    logic [7:0]              r_guard_cnt;
    logic                    r_oe;
    logic                    r_tx;
    logic                    r_tx_oe;
    logic                    r_busy;
    logic                    r_done;

    logic                    w_bit_tick;
    logic                    w_last_bit;
    logic                    w_guard_end;
    logic                    w_accept;
    logic                    w_bypass;
    logic                    w_load_hold;
    logic                    w_load;
    logic                    w_guard_entry;
    logic                    w_release;
    logic                    w_tx_nxt;
    logic                    w_busy_nxt;
    logic [UPDI_FRAME_W-1:0] w_load_frame;

    // Line ownership already dropped internally but not yet on the pins
    assign w_release = r_tx_oe & ~r_oe;

    assign o_ready      = ~r_hold_vld & (r_state != GUARD) & ~w_release;
    assign w_accept     = i_valid & o_ready;
    assign w_last_bit   = (r_state == SHIFT) & w_bit_tick & (r_bit_cnt == 4'd11);
    assign w_guard_end  = (r_state == GUARD) & w_bit_tick & (r_guard_cnt == GUARD_LAST);
    assign w_load_hold  = r_hold_vld & ((r_state == IDLE) | w_last_bit);
    // A frame offered on the final stop-bit tick goes straight to the shifter
    assign w_bypass     = w_last_bit & ~r_hold_vld & w_accept;
    assign w_load       = w_load_hold | w_bypass;
    assign w_load_frame = r_hold_vld ? r_hold : i_data;
    assign w_guard_entry = (r_state != GUARD) & (w_state_nxt == GUARD);

    updi_baud_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_baud_gen (
        .i_clk      (i_clk),
        .i_rstn     (i_rstn),
        .i_clear    (w_load | w_guard_entry),
        .i_enable   (r_state != IDLE),
        .o_bit_tick (w_bit_tick)
    );

    // FSM state register
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (r_hold_vld) begin
                    w_state_nxt = SHIFT;
                end else if (i_trans_en & r_oe) begin
                    w_state_nxt = GUARD;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            SHIFT: begin
                if (!w_last_bit) begin
                    w_state_nxt = SHIFT;
                end else if (w_load) begin
                    w_state_nxt = SHIFT;
                end else if (i_trans_en) begin
                    w_state_nxt = GUARD;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            GUARD: begin
                if (w_guard_end) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = GUARD;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Skid buffer, shifter, bit/guard counters and internal line ownership
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_hold      <= '0;
            r_hold_vld  <= 1'b0;
            r_shift     <= '1;
            r_bit_cnt   <= 4'd0;
            r_guard_cnt <= 8'd0;
            r_oe        <= 1'b0;
        end else begin
            if (w_load) begin
                r_shift   <= updi_wire_order(w_load_frame);
                r_bit_cnt <= 4'd0;
            end else if (w_last_bit) begin
                r_shift   <= {UPDI_IDLE, r_shift[UPDI_FRAME_W-1:1]};
                r_bit_cnt <= 4'd0;
            end else if ((r_state == SHIFT) && w_bit_tick) begin
                r_shift   <= {UPDI_IDLE, r_shift[UPDI_FRAME_W-1:1]};
                r_bit_cnt <= r_bit_cnt + 4'd1;
            end

            r_hold_vld <= (r_hold_vld & ~w_load_hold) | (w_accept & ~w_bypass);
            if (w_accept && !w_bypass) begin
                r_hold <= i_data;
            end

            if (w_guard_entry) begin
                r_guard_cnt <= 8'd0;
            end else if ((r_state == GUARD) && w_bit_tick) begin
                r_guard_cnt <= r_guard_cnt + 8'd1;
            end

            if (w_load) begin
                r_oe <= 1'b1;
            end else if (w_guard_end) begin
                r_oe <= 1'b0;
            end
        end
    end

    // FSM output decode
    always_comb begin
        w_tx_nxt   = UPDI_IDLE;
        w_busy_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                w_tx_nxt   = UPDI_IDLE;
                w_busy_nxt = 1'b0;
            end
            SHIFT: begin
                w_tx_nxt   = r_shift[0];
                w_busy_nxt = 1'b1;
            end
            GUARD: begin
                w_tx_nxt   = UPDI_IDLE;
                w_busy_nxt = 1'b1;
            end
            default: begin
                w_tx_nxt   = UPDI_IDLE;
                w_busy_nxt = 1'b0;
            end
        endcase
    end

    // Output registers, all sharing the same one-cycle lag behind the state
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_tx    <= UPDI_IDLE;
            r_tx_oe <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_tx    <= w_tx_nxt;
            r_tx_oe <= r_oe;
            r_busy  <= w_busy_nxt;
            r_done  <= w_release;
        end
    end

    assign o_tx    = r_tx;
    assign o_tx_oe = r_tx_oe;
    assign o_busy  = r_busy;
    assign o_done  = r_done;

endmodule

// File: tb/tb_updi_tx_serializer.sv
// Directed bench for updi_tx_serializer: CLK_DIV=4/GUARD_BITS=2 instance for
// single, back-to-back, guard and reset cases; CLK_DIV=2 instance for the reload corner.
module tb_updi_tx_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_rstn, a_valid, a_trans, a_ready, a_tx, a_oe, a_busy, a_done;
    logic [11:0] a_data;
    logic        b_rstn, b_valid, b_trans, b_ready, b_tx, b_oe, b_busy, b_done;
    logic [11:0] b_data;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n0, rel, idx;
    int acc_edge [0:7];
    logic acc;
    logic [11:0] frames [0:3];
    // Wire sequences, bit k = k-th bit on the line (hand-derived)
    logic [11:0] seq [0:3];

    updi_tx_serializer #(.CLK_DIV(4), .GUARD_BITS(2)) u_dut_a (
        .i_clk(clk), .i_rstn(a_rstn), .i_data(a_data), .i_valid(a_valid),
        .o_ready(a_ready), .i_trans_en(a_trans), .o_tx(a_tx), .o_tx_oe(a_oe),
        .o_busy(a_busy), .o_done(a_done)
    );

    updi_tx_serializer #(.CLK_DIV(2), .GUARD_BITS(1)) u_dut_b (
        .i_clk(clk), .i_rstn(b_rstn), .i_data(b_data), .i_valid(b_valid),
        .o_ready(b_ready), .i_trans_en(b_trans), .o_tx(b_tx), .o_tx_oe(b_oe),
        .o_busy(b_busy), .o_done(b_done)
    );

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    // Send one frame on instance A from IDLE and check its full bitstream
    task automatic run_frame_a(input logic [11:0] frame, input logic [11:0] wseq);
        a_valid = 1'b1;
        a_data  = frame;
        step();
        n0 = cyc;
        a_valid = 1'b0;
        chk("frame_ready_after_accept", a_ready, 0);
        for (int r = 1; r < 56; r++) begin
            step();
            if (r == 1) chk("frame_tx_before_start", a_tx, 1);
            if (r == 2) chk("frame_ready_back", a_ready, 1);
            if (r >= 2 && r < 50) chk("frame_bit", a_tx, wseq[(r - 2) / 4]);
            if (r == 10) chk("frame_busy", a_busy, 1);
            if (r == 50) chk("frame_busy_end", a_busy, 0);
            if (r >= 50) begin
                chk("frame_idle_tx", a_tx, 1);
                chk("frame_oe_kept", a_oe, 1);
            end
        end
    endtask

    initial begin
        frames[0] = 12'h2AB; frames[1] = 12'h283; frames[2] = 12'h2AB; frames[3] = 12'h283;
        seq[0] = 12'hCAA; seq[1] = 12'hCA0; seq[2] = 12'hCAA; seq[3] = 12'hCA0;
        for (int i = 0; i < 8; i++) acc_edge[i] = 0;
        a_rstn = 1'b0; a_valid = 1'b0; a_trans = 1'b0; a_data = 12'h000;
        b_rstn = 1'b0; b_valid = 1'b0; b_trans = 1'b0; b_data = 12'h000;
        step();
        step();
        chk("rst_tx", a_tx, 1);
        chk("rst_oe", a_oe, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_done", a_done, 0);
        chk("rst_ready", a_ready, 1);
        chk("rst_b_tx", b_tx, 1);
        a_rstn = 1'b1;
        b_rstn = 1'b1;
        step();

        // Single frame 0x2AB, trans_en low
        run_frame_a(12'h2AB, seq[0]);

        // Three frames with valid held, trans_en after third accept, then a GUARD attempt
        idx = 0;
        a_valid = 1'b1;
        a_data  = frames[0];
        for (int c = 0; c < 215; c++) begin
            acc = a_valid & a_ready;
            step();
            if (acc) begin
                if (idx < 8) acc_edge[idx] = cyc;
                idx++;
                a_valid = 1'b0;
                if (idx < 3) begin
                    a_valid = 1'b1;
                    a_data  = frames[idx];
                end
                if (idx == 3) a_trans = 1'b1;
            end
            if (idx > 0) begin
                rel = cyc - acc_edge[0];
                if (rel >= 2 && rel < 146) chk("b2b_stream", a_tx, seq[(rel - 2) / 48][((rel - 2) % 48) / 4]);
                if (rel == 30) chk("b2b_ready_hold_full", a_ready, 0);
                if (rel >= 146 && rel < 154) begin
                    chk("guard_tx", a_tx, 1);
                    chk("guard_oe", a_oe, 1);
                    chk("guard_ready", a_ready, 0);
                end
                if (rel == 147) begin
                    a_valid = 1'b1;
                    a_data  = frames[3];
                end
                if (rel == 154) begin
                    chk("release_oe", a_oe, 0);
                    chk("release_done", a_done, 1);
                    chk("release_busy", a_busy, 0);
                    chk("release_ready", a_ready, 1);
                    a_trans = 1'b0;
                end
                if (rel == 155) chk("done_single_pulse", a_done, 0);
                if (rel == 157) chk("post_guard_oe", a_oe, 1);
                if (rel >= 157 && rel < 205) chk("post_guard_stream", a_tx, seq[3][(rel - 157) / 4]);
            end
        end
        chk("accept_count", idx, 4);
        chk("accept2_edge", acc_edge[1] - acc_edge[0], 2);
        chk("accept3_edge", acc_edge[2] - acc_edge[0], 50);
        chk("accept4_edge", acc_edge[3] - acc_edge[0], 155);

        // Reset in the middle of bit 5, then a clean frame
        a_valid = 1'b1;
        a_data  = 12'h2AB;
        step();
        n0 = cyc;
        a_valid = 1'b0;
        for (int r = 1; r < 23; r++) step();
        a_rstn = 1'b0;
        step();
        chk("midrst_tx", a_tx, 1);
        chk("midrst_oe", a_oe, 0);
        chk("midrst_ready", a_ready, 1);
        chk("midrst_busy", a_busy, 0);
        a_rstn = 1'b1;
        step();
        run_frame_a(12'h283, seq[1]);

        // CLK_DIV=2: second frame offered exactly on the last stop-bit tick
        b_valid = 1'b1;
        b_data  = 12'h2AB;
        step();
        n0 = cyc;
        b_valid = 1'b0;
        for (int r = 1; r < 53; r++) begin
            step();
            if (r == 1) chk("cd2_tx_before_start", b_tx, 1);
            if (r >= 2 && r < 50) chk("cd2_stream", b_tx, seq[(r - 2) / 24][((r - 2) % 24) / 2]);
            if (r >= 50) chk("cd2_idle", b_tx, 1);
            if (r == 24) begin
                chk("cd2_ready_at_tick", b_ready, 1);
                b_valid = 1'b1;
                b_data  = 12'h283;
            end
            if (r == 25) b_valid = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
